// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master.
//   wb_state_e : control-FSM state encoding (IDLE, FETCH, STROBE, FINISH)
//   byte_inc() : address step per beat, in bytes, for a given data width
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STROBE = 2'd2,
    ST_FINISH = 2'd3
  } wb_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Byte-addressed bus: each beat moves the address by one data word.
  function automatic int unsigned byte_inc(input int unsigned data_w);
    return data_w / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts consecutive cycles in which a strobe is outstanding without a slave
// response, and flags expiry on the TIMEOUT-th such cycle.
// Ports:
//   clk_i   in  clock, rising edge
//   rst_i   in  synchronous active-high reset
//   clr     in  clear the count (slave responded, or no strobe outstanding)
//   en      in  count this cycle (strobe outstanding, no response)
//   expired out high in the cycle the count reaches TIMEOUT
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the idle cycles already elapsed, so the current idle cycle is
  // number cnt_q+1; expiry fires combinationally on the TIMEOUT-th one.
  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone (classic, byte-addressed) burst master. Accepts a read or write
// request of 1..MAX_BURST beats from the core side, runs the beats on the
// bus one at a time, and reports completion with a one-cycle done pulse.
// Ports:
//   clk_i, rst_i                       clock / synchronous active-high reset
//   req_valid, req_ready               request handshake (accepted when both high)
//   req_we, req_addr, req_len          request direction, start address, beat count
//   wdata_valid, wdata, wdata_ready    write-data handshake, one word per beat
//   rdata_valid, rdata                 read beat data, one-cycle pulse per beat
//   done, err                          request finished pulse; err = aborted
//   adr_o, dat_o, sel_o, we_o,
//   stb_o, cyc_o                       Wishbone master outputs
//   dat_i, ack_i, err_i                Wishbone slave responses
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [$clog2(MAX_BURST):0]  req_len,
  input  logic                        wdata_valid,
  input  logic [DATA_W-1:0]           wdata,
  output logic                        wdata_ready,
  output logic                        rdata_valid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_W-1:0]           adr_o,
  output logic [DATA_W-1:0]           dat_o,
  output logic [DATA_W/8-1:0]         sel_o,
  output logic                        we_o,
  output logic                        stb_o,
  output logic                        cyc_o,
  input  logic [DATA_W-1:0]           dat_i,
  input  logic                        ack_i,
  input  logic                        err_i
);

  localparam int unsigned      LEN_W    = $clog2(MAX_BURST) + 1;
  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(byte_inc(DATA_W));

  wb_state_e           state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvld_q, rvld_d;
  logic                err_q, err_d;

  logic tmo_en, tmo_clr, tmo_expired;

  // Out-of-range lengths (zero or above MAX_BURST) fall back to a single beat.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (len > LEN_W'(MAX_BURST))) begin
      return LEN_W'(1);
    end
    return len;
  endfunction

  // Only a strobe left unanswered counts towards the timeout; waiting for
  // core write data in FETCH never does.
  assign tmo_en  = (state_q == ST_STROBE) && !ack_i && !err_i;
  assign tmo_clr = !tmo_en;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rem_d       = rem_q;
    rdata_d     = rdata_q;
    rvld_d      = 1'b0;
    err_d       = err_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    sel_o       = '0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          adr_d   = req_addr;
          rem_d   = norm_len(req_len);
          err_d   = 1'b0;
          state_d = req_we ? ST_FETCH : ST_STROBE;
        end
      end

      ST_FETCH: begin
        cyc_o       = 1'b1;
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          dat_d   = wdata;
          state_d = ST_STROBE;
        end
      end

      ST_STROBE: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        sel_o = '1;
        // A bus error outranks an ack in the same cycle; timeout is an abort too.
        if (err_i || tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (ack_i) begin
          if (!we_q) begin
            rdata_d = dat_i;
            rvld_d  = 1'b1;
          end
          adr_d = adr_q + ADR_STEP;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_FINISH;
          end else if (we_q) begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rem_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
    end
  end

  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
  assign err         = err_q;

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameters: ADDR_W, default 26, bus address width; DATA_W, default 32, data width (multiple of 8); MAX_BURST, default 8, max beats per request; TIMEOUT, default 16, idle-ack cycles before abort.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge; rst_i  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both high; req_we  in  1  1=write 0=read; req_addr  in  ADDR_W  start address; req_len  in  clog2(MAX_BURST)+1  beat count.
REQ-004 SHALL have ports: wdata_valid  in  1; wdata  in  DATA_W; wdata_ready  out  1  write-data handshake, one word per beat.
REQ-005 SHALL have ports: rdata_valid  out  1; rdata  out  DATA_W  read beat data; done  out  1  request finished pulse; err  out  1  abort flag, qualified by done.
REQ-006 SHALL have Wishbone ports: adr_o  out  ADDR_W; dat_o  out  DATA_W; sel_o  out  DATA_W/8; we_o  out  1; stb_o  out  1; cyc_o  out  1; dat_i  in  DATA_W; ack_i  in  1; err_i  in  1.

Function
REQ-007 SHALL implement states IDLE, FETCH, STROBE, FINISH; req_ready high only in IDLE.
REQ-008 SHALL, on req_valid&req_ready, latch we, addr, len; req_len 0 or >MAX_BURST treated as 1.
REQ-009 SHALL go IDLE->STROBE for reads, IDLE->FETCH for writes; cyc_o high in FETCH and STROBE.
REQ-010 SHALL, in FETCH, assert wdata_ready, stb_o low; on wdata_valid latch wdata into dat_o and go STROBE next cycle.
REQ-011 SHALL, in STROBE, hold stb_o, adr_o, we_o, dat_o, sel_o all-ones stable until ack_i or err_i.
REQ-012 SHALL, on ack_i in STROBE: read -> rdata<=dat_i, rdata_valid pulse next cycle; advance adr by DATA_W/8 (wraps modulo 2^ADDR_W); decrement remaining beats.
REQ-013 SHALL, after ack of last beat, go FINISH; else return FETCH (write) or stay STROBE (read) with stb_o deasserted one cycle between beats not required.
REQ-014 SHALL, on err_i in STROBE (priority over ack_i when both high), abort: go FINISH with err set, no further beats.
REQ-015 SHALL count consecutive STROBE cycles without ack_i/err_i; counter reaching TIMEOUT aborts as REQ-014; counter clears on every ack.
REQ-016 SHALL not time out in FETCH (core-side stall is unbounded).
REQ-017 SHALL, in FINISH, drop cyc_o/stb_o, pulse done for one cycle, go IDLE; err cleared on next accepted request.
REQ-018 SHALL give latency: read beat, ack cycle +1 to rdata_valid; done one cycle after final ack.

Reset
REQ-019 SHALL, on rst_i at clk_i edge, enter IDLE; stb_o, cyc_o, we_o, wdata_ready, rdata_valid, done, err = 0; adr_o, dat_o, rdata, counters = 0; sel_o = 0.
REQ-020 SHALL treat reset mid-burst as immediate abort: cyc_o low next cycle, no done pulse.

Structure
REQ-021 SHALL place state encoding and the byte-increment constant in shared package wb_pkg.
REQ-022 SHALL implement the timeout as sub-module wb_timeout_ctr (params TIMEOUT; ports clr, en, expired).

Verification
REQ-023 Read len=4 addr=0x100, slave acks each cycle -> adr_o 0x100,0x104,0x108,0x10C; 4 rdata_valid; done 1 cycle after 4th ack, err=0.
REQ-024 Write len=2, wdata_valid delayed 3 cycles on beat 2 -> stb_o low during wait, cyc_o high, dat_o matches each word, done, err=0.
REQ-025 Read len=3, err_i on beat 2 with ack_i -> abort, 1 rdata_valid, done with err=1, adr_o never 0x108.
REQ-026 TIMEOUT=16, slave never acks -> stb_o high 16 cycles, then done with err=1, cyc_o low.
REQ-027 req_len=0 and addr=2^ADDR_W-4, len=2 -> first is 1 beat; second wraps adr_o to 0.
REQ-028 rst_i asserted during beat 3 of len 8 -> cyc_o low next cycle, no done, req_ready high after reset.
